datapath_gen2: RTL and testbench
================================

# datapath_gen2

Parametrised successor to the 8-bit CPU datapath: register file, ALU with latched status flags, instruction register, and a program counter with increment, jump, conditional branch and a hardware call/return stack. It sits between the control unit, which drives the decoded control fields, and the program ROM and shared data bus. Width, register count, program-address width and stack depth are parameters. A global stall freezes all architectural state.

## Interface
- W, 8: data/register width (≥4)
- NREG, 8: register count, power of two; RA = log2(NREG) select width
- PW, 8: program address width (≤ W)
- IW, 16: instruction width
- SD, 4: call-stack depth (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- data  inout  W  shared bus; driven with ALU result when en_alu=1, else high-Z
- K  in  W  immediate constant; also jump/call target, truncated to PW bits
- wa, ra, rb  in  RA each  write / A-read / B-read register selects
- w  in  1  register write enable; writes data bus into wa
- a_sel  in  1  ALU A = zero-extended pc (1) or reg[ra] (0)
- b_sel  in  1  ALU B = K (1) or reg[rb] (0)
- fs  in  3  ALU function
- ci  in  1  ALU carry in
- en_alu  in  1  drive data bus
- sl  in  1  latch ALU status
- il  in  1  load instruction register from rom_data
- pc_op  in  3  0 HOLD, 1 INC, 2 JMP(K), 3 LDBUS(data), 4 BR, 5 CALL, 6 RET, 7 HOLD
- cond  in  2  status bit index tested by BR
- cond_inv  in  1  invert the BR condition
- stall  in  1  freeze all state
- fault_clr  in  1  clear sticky faults
- rom_data  in  IW  ROM word at pc
- pc  out  PW  program counter, also ROM address
- addr  out  W  memory address, equal to K (combinational)
- I  out  IW  instruction register
- status  out  4  latched {V,C,N,Z}
- stk_full, stk_empty  out  1  stack occupancy == SD / == 0
- fault  out  2  sticky {underflow, overflow}
- dbg_sel  in  RA; dbg_reg  out  W  combinational register readback

## Operation
- ALU ops, with F of width W:
  - 0 ADD: A+B+ci
  - 1 SUB: A+~B+ci
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL: A<<1, C = A[W-1]
  - 7 SHR: logical A>>1, C = A[0]
- ALU flags:
  - Z = (F==0)
  - N = F[W-1]
  - C = carry out of bit W-1 (ADD/SUB) or the shifted-out bit; 0 for logic ops
  - V = signed overflow for ADD/SUB; 0 otherwise
- Register file: NREG×W. Write reg[wa] <= data when w=1. Reads are combinational. There is no hardwired zero register.
- PC update when not stalled:
  - INC: pc+1, wraps from 2^PW-1 to 0
  - JMP: K[PW-1:0]
  - LDBUS: data[PW-1:0]
  - BR: taken iff status[cond]^cond_inv; taken → K[PW-1:0], else pc+1
  - CALL: push pc+1 (wrapped), then pc <= K[PW-1:0]
  - RET: pop into pc
- CALL with stk_full: no push and pc holds; set fault[0].
- RET with stk_empty: pc holds; set fault[1].
- BR tests the status value latched before the edge, even if sl=1 in the same cycle.
- LDBUS with en_alu=1 loads the ALU result.
- fault_clr clears both fault bits. A fault event in the same cycle wins.

## Timing
- All state updates on the rising clk edge. ALU, addr, dbg_reg and the data-bus drive are combinational.
- A register written at edge n is readable from cycle n+1. Write-then-read in the same cycle returns the old value; there is no bypass.
- Reset (rst=0, async) clears:
  - all registers, pc, I, status, stack pointer and stack contents, fault → 0
  - so stk_empty=1, stk_full=0
- Recovery: the first update happens at the first rising edge after rst deasserts.
- stall=1 blocks every state update: regs, pc, I, status, stack, fault, including fault_clr. Combinational outputs stay live, and the bus is still driven if en_alu=1.
- CALL/RET take effect in one cycle. Back-to-back CALLs fill the stack at one entry per cycle.

## Structure
- Shared package datapath_pkg:
  - fs encodings
  - pc_op encodings
  - status bit indices (Z=0, N=1, C=2, V=3)
  - fault bit indices
- Sub-module alu_param (W): the combinational ALU plus flag generation.
- Register file, stack (array + pointer) and PC logic stay in the top. No RAM macros.

## Test plan
- Reset with W=8, then w=1 with the bus driven to 0x5A, wa=3 → next cycle ra=3 gives dbg_reg/ALU A = 0x5A. Asserting rst mid-run returns pc=0, status=0.
- ADD with reg=0x7F, K=0x01, b_sel=1, sl=1 → F=0x80, status {V,C,N,Z} = 1,0,1,0. SUB with 0x10−0x10 (ci=1) → Z=1, C=1.
- pc=0xFF with INC → 0x00. BR with cond=Z, Z=1, K=0x40 → pc=0x40; same with cond_inv=1 → pc=pc+1.
- SD=4: CALLs to 0x10, 0x20, 0x30, 0x40, then a 5th CALL → pc stays 0x40, fault=01, stk_full=1. Four RETs → pc 0x31, 0x21, 0x11, then original+1. A 5th RET → fault=11.
- stall=1 with CALL, w=1, sl=1, il=1 → no state changes. Release stall → the operation executes once.
- fault_clr with no new fault → fault=00. fault_clr together with an underflow RET → fault[1]=1.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared encodings for the generation-2 CPU datapath: ALU functions, PC operations,
// status and fault bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    FsAdd = 3'd0,
    FsSub = 3'd1,
    FsAnd = 3'd2,
    FsOr  = 3'd3,
    FsXor = 3'd4,
    FsNot = 3'd5,
    FsShl = 3'd6,
    FsShr = 3'd7
  } fs_e;

  typedef enum logic [2:0] {
    PcHold    = 3'd0,
    PcInc     = 3'd1,
    PcJmp     = 3'd2,
    PcLdBus   = 3'd3,
    PcBr      = 3'd4,
    PcCall    = 3'd5,
    PcRet     = 3'd6,
    PcHoldAlt = 3'd7
  } pc_op_e;

  localparam int unsigned StZ = 0;
  localparam int unsigned StN = 1;
  localparam int unsigned StC = 2;
  localparam int unsigned StV = 3;

  localparam int unsigned FaultOvf = 0;
  localparam int unsigned FaultUnf = 1;

endpackage

// File: rtl/alu_param.sv
// Combinational W-bit ALU with {V,C,N,Z} flag generation.
module alu_param
  import datapath_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   fs,
  input  logic         ci,
  output logic [W-1:0] f,
  output logic [3:0]   flags
);

  logic [W-1:0] add_b;
  logic [W:0]   sum;
  logic         c, v;

  // SUB reuses the adder with an inverted B operand.
  assign add_b = (fs == FsSub) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, add_b} + {{W{1'b0}}, ci};

  always_comb begin
    f = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (fs_e'(fs))
      FsAdd, FsSub: begin
        f = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == add_b[W-1]) && (sum[W-1] != a[W-1]);
      end
      FsAnd: f = a & b;
      FsOr:  f = a | b;
      FsXor: f = a ^ b;
      FsNot: f = ~a;
      FsShl: begin
        f = {a[W-2:0], 1'b0};
        c = a[W-1];
      end
      FsShr: begin
        f = {1'b0, a[W-1:1]};
        c = a[0];
      end
    endcase
  end

  assign flags = {v, c, f[W-1], (f == '0)};

endmodule

// File: rtl/datapath_gen2.sv
// Parametrised CPU datapath: register file, ALU with latched status, instruction
// register and a program counter with branch plus hardware call/return stack.
module datapath_gen2
  import datapath_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned PW   = 8,
  parameter int unsigned IW   = 16,
  parameter int unsigned SD   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  inout  logic [W-1:0]            data,
  input  logic [W-1:0]            K,
  input  logic [$clog2(NREG)-1:0] wa,
  input  logic [$clog2(NREG)-1:0] ra,
  input  logic [$clog2(NREG)-1:0] rb,
  input  logic                    w,
  input  logic                    a_sel,
  input  logic                    b_sel,
  input  logic [2:0]              fs,
  input  logic                    ci,
  input  logic                    en_alu,
  input  logic                    sl,
  input  logic                    il,
  input  logic [2:0]              pc_op,
  input  logic [1:0]              cond,
  input  logic                    cond_inv,
  input  logic                    stall,
  input  logic                    fault_clr,
  input  logic [IW-1:0]           rom_data,
  output logic [PW-1:0]           pc,
  output logic [W-1:0]            addr,
  output logic [IW-1:0]           I,
  output logic [3:0]              status,
  output logic                    stk_full,
  output logic                    stk_empty,
  output logic [1:0]              fault,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [W-1:0]            dbg_reg
);

  localparam int unsigned SPW = $clog2(SD + 1);
  localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;

  logic [W-1:0]   regs_q [NREG];
  logic [PW-1:0]  stk_q  [SD];
  logic [SPW-1:0] sp_q, sp_d;
  logic [PW-1:0]  pc_q, pc_d, pc_inc;
  logic [IW-1:0]  ir_q;
  logic [3:0]     status_q;
  logic [1:0]     fault_q, fault_d;
  logic           push;
  logic [SIW-1:0] push_idx, pop_idx;

  logic [W-1:0] alu_a, alu_b, alu_f;
  logic [3:0]   alu_flags;

  assign alu_a = a_sel ? W'(pc_q) : regs_q[ra];
  assign alu_b = b_sel ? K : regs_q[rb];

  alu_param #(.W(W)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .fs    (fs),
    .ci    (ci),
    .f     (alu_f),
    .flags (alu_flags)
  );

  assign data      = en_alu ? alu_f : 'z;
  assign addr      = K;
  assign dbg_reg   = regs_q[dbg_sel];
  assign pc        = pc_q;
  assign I         = ir_q;
  assign status    = status_q;
  assign fault     = fault_q;
  assign stk_full  = (sp_q == SPW'(SD));
  assign stk_empty = (sp_q == '0);

  assign pc_inc   = pc_q + PW'(1);
  assign push_idx = sp_q[SIW-1:0];
  assign pop_idx  = SIW'(sp_q - SPW'(1));

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    // A fault raised this cycle overrides the clear.
    fault_d = fault_clr ? 2'b00 : fault_q;
    unique case (pc_op_e'(pc_op))
      PcHold, PcHoldAlt: ;
      PcInc:   pc_d = pc_inc;
      PcJmp:   pc_d = K[PW-1:0];
      PcLdBus: pc_d = data[PW-1:0];
      PcBr:    pc_d = (status_q[cond] ^ cond_inv) ? K[PW-1:0] : pc_inc;
      PcCall: begin
        if (stk_full) begin
          fault_d[FaultOvf] = 1'b1;
        end else begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
          pc_d = K[PW-1:0];
        end
      end
      PcRet: begin
        if (stk_empty) begin
          fault_d[FaultUnf] = 1'b1;
        end else begin
          sp_d = sp_q - SPW'(1);
          pc_d = stk_q[pop_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int i = 0; i < SD; i++) stk_q[i] <= '0;
      sp_q     <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      status_q <= '0;
      fault_q  <= '0;
    end else if (!stall) begin
      if (w)    regs_q[wa] <= data;
      if (push) stk_q[push_idx] <= pc_inc;
      if (sl)   status_q <= alu_flags;
      if (il)   ir_q <= rom_data;
      sp_q    <= sp_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_datapath_gen2.sv
// Scoreboard bench for datapath_gen2: directed scenarios plus random stimulus against
// a behavioural model; a monitor checks post-edge state from an expectation queue.
module tb_datapath_gen2;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  K, tb_data;
  wire  [7:0]  data;
  logic [2:0]  wa, ra, rb, dbg_sel, fs, pc_op;
  logic        w, a_sel, b_sel, ci, en_alu, sl, il, cond_inv, stall, fault_clr;
  logic [1:0]  cond;
  logic [15:0] rom_data;
  logic [7:0]  pc, addr, dbg_reg;
  logic [15:0] I;
  logic [3:0]  status;
  logic        stk_full, stk_empty;
  logic [1:0]  fault;

  assign data = en_alu ? 8'hzz : tb_data;

  always #5 clk = ~clk;

  datapath_gen2 dut (
    .clk(clk), .rst(rst), .data(data), .K(K), .wa(wa), .ra(ra), .rb(rb), .w(w),
    .a_sel(a_sel), .b_sel(b_sel), .fs(fs), .ci(ci), .en_alu(en_alu), .sl(sl), .il(il),
    .pc_op(pc_op), .cond(cond), .cond_inv(cond_inv), .stall(stall), .fault_clr(fault_clr),
    .rom_data(rom_data), .pc(pc), .addr(addr), .I(I), .status(status),
    .stk_full(stk_full), .stk_empty(stk_empty), .fault(fault), .dbg_sel(dbg_sel),
    .dbg_reg(dbg_reg)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [7:0]  m_reg [8];
  logic [7:0]  m_pc;
  logic [3:0]  m_st;
  logic [1:0]  m_fault;
  logic [15:0] m_ir;
  logic [7:0]  m_stk [$];

  typedef struct {
    logic [7:0]  pc;
    logic [3:0]  st;
    logic [1:0]  fault;
    logic        full;
    logic        empty;
    logic [15:0] ir;
  } exp_t;
  exp_t exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_pc = 0; m_st = 0; m_fault = 0; m_ir = 0;
    m_stk.delete();
  endtask

  function automatic int sx(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  task automatic alu_m(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f_sel,
                       input logic c_in, output logic [7:0] f, output logic [3:0] fl);
    logic [7:0] bb;
    int u, s;
    logic c, v;
    c = 0; v = 0; f = 0;
    case (f_sel)
      3'd0, 3'd1: begin
        bb = (f_sel == 3'd1) ? 8'(255 - int'(b)) : b;
        u  = int'(a) + int'(bb) + int'(c_in);
        s  = sx(a) + sx(bb) + int'(c_in);
        f  = u[7:0];
        c  = (u > 255);
        v  = (s > 127) || (s < -128);
      end
      3'd2: f = a & b;
      3'd3: f = a | b;
      3'd4: f = a ^ b;
      3'd5: f = ~a;
      3'd6: begin f = {a[6:0], 1'b0}; c = a[7]; end
      default: begin f = {1'b0, a[7:1]}; c = a[0]; end
    endcase
    fl = {v, c, f[7], f == 8'h00};
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    logic [7:0] a, b, f, bus, inc;
    logic [3:0] fl;
    exp_t e;
    #1;
    a = a_sel ? m_pc : m_reg[ra];
    b = b_sel ? K : m_reg[rb];
    alu_m(a, b, fs, ci, f, fl);
    bus = en_alu ? f : tb_data;
    chk("dbg_reg", dbg_reg, m_reg[dbg_sel]);
    chk("addr", addr, K);
    if (en_alu) chk("bus_alu", data, f);
    if (!stall) begin
      inc = m_pc + 8'd1;
      if (fault_clr) m_fault = 2'b00;
      case (pc_op)
        3'd1: m_pc = inc;
        3'd2: m_pc = K;
        3'd3: m_pc = bus;
        3'd4: m_pc = (m_st[cond] ^ cond_inv) ? K : inc;
        3'd5: if (m_stk.size() == SD) m_fault[0] = 1'b1;
              else begin m_stk.push_back(inc); m_pc = K; end
        3'd6: if (m_stk.size() == 0) m_fault[1] = 1'b1;
              else m_pc = m_stk.pop_back();
        default: ;
      endcase
      if (w)  m_reg[wa] = bus;
      if (sl) m_st = fl;
      if (il) m_ir = rom_data;
    end
    e.pc = m_pc; e.st = m_st; e.fault = m_fault; e.ir = m_ir;
    e.full = (m_stk.size() == SD); e.empty = (m_stk.size() == 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every rising edge consumes one expectation, if present.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("status", status, e.st);
        chk("fault", fault, e.fault);
        chk("stk_full", stk_full, e.full);
        chk("stk_empty", stk_empty, e.empty);
        chk("ir", I, e.ir);
      end
    end
  end

  task automatic idle();
    K = 0; tb_data = 0; wa = 0; ra = 0; rb = 0; dbg_sel = 0; fs = 0; pc_op = 0;
    w = 0; a_sel = 0; b_sel = 0; ci = 0; en_alu = 0; sl = 0; il = 0; cond = 0;
    cond_inv = 0; stall = 0; fault_clr = 0; rom_data = 0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_status", status, 4'h0);
    chk("rst_fault", fault, 2'b00);
    chk("rst_empty", stk_empty, 1'b1);
    chk("rst_full", stk_full, 1'b0);
    chk("rst_ir", I, 16'h0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk("rst_reg", dbg_reg, 8'h00);
    end
    dbg_sel = 0;
    @(negedge clk);
    rst = 1'b1;

    // Register write then read back
    w = 1; wa = 3; tb_data = 8'h5a; tick();
    idle(); ra = 3; dbg_sel = 3; en_alu = 1; fs = 3'd3;
    #1 chk("reg3_readback", dbg_reg, 8'h5a);
    tick();
    // Write and read of the same register in one cycle sees the old value
    idle(); w = 1; wa = 4; tb_data = 8'h33; dbg_sel = 4; tick();

    // ADD overflow flags
    idle(); w = 1; wa = 1; tb_data = 8'h7f; tick();
    idle(); ra = 1; K = 8'h01; b_sel = 1; fs = 3'd0; sl = 1; en_alu = 1;
    #1 chk("add_result", data, 8'h80);
    tick();
    chk("add_status", status, 4'b1010);

    // SUB equal operands
    idle(); w = 1; wa = 2; tb_data = 8'h10; tick();
    idle(); ra = 2; K = 8'h10; b_sel = 1; fs = 3'd1; ci = 1; sl = 1; tick();
    chk("sub_status", status, 4'b0101);

    // PC wrap and branches
    idle(); pc_op = 3'd2; K = 8'hff; tick();
    idle(); pc_op = 3'd1; tick();
    chk("pc_wrap", pc, 8'h00);
    idle(); pc_op = 3'd4; cond = 0; K = 8'h40; tick();
    chk("br_taken", pc, 8'h40);
    idle(); pc_op = 3'd4; cond = 0; cond_inv = 1; K = 8'h40; tick();
    chk("br_not_taken", pc, 8'h41);
    // Branch sees pre-edge Z even though sl clears it in the same cycle
    idle(); pc_op = 3'd4; cond = 0; K = 8'h60; b_sel = 1; fs = 3'd3; sl = 1; tick();
    chk("br_old_status", pc, 8'h60);

    // Call stack fill, overflow, drain, underflow
    idle(); pc_op = 3'd2; K = 8'h05; tick();
    for (int k = 1; k <= 4; k++) begin
      idle(); pc_op = 3'd5; K = 8'(k * 16); tick();
    end
    chk("call4_pc", pc, 8'h40);
    chk("call4_full", stk_full, 1'b1);
    idle(); pc_op = 3'd5; K = 8'h50; tick();
    chk("call_ovf_pc", pc, 8'h40);
    chk("call_ovf_fault", fault, 2'b01);
    idle(); pc_op = 3'd6; tick(); chk("ret1", pc, 8'h31);
    tick(); chk("ret2", pc, 8'h21);
    tick(); chk("ret3", pc, 8'h11);
    tick(); chk("ret4", pc, 8'h06);
    tick(); chk("ret_unf_fault", fault, 2'b11);

    idle(); fault_clr = 1; tick();
    chk("fault_clr", fault, 2'b00);
    idle(); fault_clr = 1; pc_op = 3'd6; tick();
    chk("fault_clr_vs_unf", fault, 2'b10);

    // Stall freezes everything, including fault_clr
    idle(); stall = 1; pc_op = 3'd5; K = 8'h77; w = 1; wa = 5; tb_data = 8'ha5;
    sl = 1; fs = 3'd5; il = 1; rom_data = 16'hbeef; fault_clr = 1; tick();
    chk("stall_pc", pc, 8'h06);
    chk("stall_fault", fault, 2'b10);
    stall = 0; tick();
    chk("unstall_pc", pc, 8'h77);
    chk("unstall_ir", I, 16'hbeef);
    idle(); dbg_sel = 5; tick();
    chk("unstall_once", pc, 8'h77);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      K = 8'($urandom); tb_data = 8'($urandom); wa = 3'($urandom); ra = 3'($urandom);
      rb = 3'($urandom); dbg_sel = 3'($urandom); fs = 3'($urandom); pc_op = 3'($urandom);
      w = 1'($urandom); a_sel = 1'($urandom); b_sel = 1'($urandom); ci = 1'($urandom);
      en_alu = 1'($urandom); sl = 1'($urandom); il = 1'($urandom);
      cond = 2'($urandom); cond_inv = 1'($urandom); rom_data = 16'($urandom);
      stall = ($urandom_range(0, 7) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      tick();
    end

    // Asynchronous reset mid-run
    idle(); rst = 1'b0;
    #1;
    chk("midrst_pc", pc, 8'h00);
    chk("midrst_status", status, 4'h0);
    chk("midrst_empty", stk_empty, 1'b1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      K = 8'($urandom); tb_data = 8'($urandom); wa = 3'($urandom); ra = 3'($urandom);
      dbg_sel = 3'($urandom); fs = 3'($urandom); pc_op = 3'($urandom); w = 1'($urandom);
      sl = 1'($urandom); en_alu = 1'($urandom); b_sel = 1'($urandom);
      tick();
    end

    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
